aud_player_loop: RTL and testbench
==================================

// Module: aud_player_loop
// PURPOSE
//  I2S transmitter: plays a mono 16-bit sample buffer from SRAM out to the WM8731 DACDAT pin, looping forever.
//  Each sample is sent MSB-first, with a one-BCLK delay after each DACLRCK edge, on both the left and right channels.
//  It is the playback counterpart of the loop recorder and shares its SRAM map: addresses 0..MAX_ADDR, wrapping to 0.
//  Clocked by BCLK; the SRAM read port is asynchronous, and data must be valid before the next DACLRCK fall.
// PARAMETERS
//  MAX_ADDR  20'd524_287  last buffer address; the next address after it is 0
// PORTS
//  i_clk         in   1   BCLK from WM8731; all state updates on posedge
//  i_rst_n       in   1   reset, asynchronous, active-low
//  i_daclrck     in   1   DACLRCK; 0 = left half, 1 = right half
//  i_start       in   1   play from address 0 (also restarts if already playing)
//  i_pause       in   1   pause at the next frame boundary
//  i_resume      in   1   leave pause
//  i_stop        in   1   stop immediately, address back to 0
//  i_sram_data   in   16  sample at o_address
//  o_address     out  20  SRAM read address
//  o_dac_data    out  1   DACDAT serial bit
//  o_playing     out  1   1 in S_SYNC/S_PLAY
//  o_wrap        out  1   1-cycle pulse when o_address wraps MAX_ADDR->0
// BEHAVIOUR
//  Reset state: S_IDLE; o_address=0, o_dac_data=0, o_playing=0, o_wrap=0.
//  Reset state: lrc_d=0, shift/hold regs=0, bit_cnt=0, pause_pend=0.
//  Edge detect: lrc_d <= i_daclrck each cycle.
//   fall = lrc_d & ~i_daclrck; rise = ~lrc_d & i_daclrck.
//   Because lrc_d resets to 0, no false fall is seen after reset.
//  Command priority, evaluated every cycle: stop > start > pause > resume.
//  States:
//   S_IDLE:  outputs 0. i_start -> S_SYNC, o_address<=0.
//   S_SYNC:  o_dac_data=0. On fall -> S_PLAY, left-load (below) in the same cycle.
//   S_PLAY:  serialise.
//    fall with pause_pend=0: left-load.
//     hold<=i_sram_data, o_dac_data<=i_sram_data[15], shift<=i_sram_data<<1, bit_cnt<=1.
//    fall with pause_pend=1: -> S_PAUSE, o_dac_data<=0, pause_pend<=0.
//    rise: right-load, same as left-load but sourced from hold.
//     Same posedge: o_address <= (o_address==MAX_ADDR) ? 0 : o_address+1.
//     o_wrap=1 for that cycle on wrap.
//    Otherwise, if 1<=bit_cnt<=15: o_dac_data<=shift[15], shift<<=1, bit_cnt++.
//    If bit_cnt==16: o_dac_data<=0, bit_cnt held at 16 (idle bits until next edge).
//    i_pause sets pause_pend.
//   S_PAUSE: o_dac_data=0, o_address held.
//    i_resume -> S_SYNC; playback restarts on the next fall at the held address.
//  Timing: MSB is driven on the posedge that detects the edge.
//   The receiver samples bit k (k=1..16) on the k-th posedge after that one (I2S 1-bit delay).
//  Short half (<17 BCLK): an edge always restarts serialisation; unsent bits are dropped.
//  i_stop in any state: next cycle S_IDLE, o_address=0, o_dac_data=0, pause_pend=0.
//  i_start in S_PLAY/S_PAUSE: o_address<=0, -> S_SYNC; the current bit is cut and o_dac_data<=0.
//  i_pause in S_IDLE/S_SYNC: ignored. i_resume outside S_PAUSE: ignored.
//  Async reset mid-frame: all outputs return to reset values at once.
//   No resumption; i_start is required.
// TESTING
//  T1 reset: assert i_rst_n=0 mid-frame -> o_address=0, o_dac_data=0, o_playing=0, o_wrap=0 immediately.
//  T2 serialise: i_start, SRAM[0]=16'hA5C3, LRCK half=32 BCLK.
//   -> Bits 1010_0101_1100_0011 sampled on posedges 1..16 after the fall, then 0.
//   -> The same 16 bits after the rise; o_address 0->1 on the rise posedge.
//  T3 wrap: MAX_ADDR=3, 5 frames -> o_address 0,1,2,3,0; o_wrap high exactly 1 cycle, at the 3->0 rise.
//  T4 pause: i_pause during left half at address 5.
//   -> The frame completes (left and right), o_address=6.
//   -> Next fall enters S_PAUSE with o_dac_data=0.
//   -> i_resume: SRAM[6] is played after the following fall.
//  T5 stop priority: i_start & i_stop in the same cycle in S_PLAY -> S_IDLE, o_address=0, o_dac_data=0.
//  T6 loopback: o_dac_data/i_daclrck into the loop recorder's i_data/i_lrc, ramp buffer 0..99.
//   -> The recorder captures the identical samples in order.

Source files
------------

// File: rtl/aud_player_loop.sv
// I2S playback of a mono 16-bit SRAM loop buffer to the WM8731 DACDAT pin.
// The same sample goes out on the left and right halves; the buffer address advances once per frame.
module aud_player_loop #(
    parameter logic [19:0] MAX_ADDR = 20'd524_287
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_daclrck,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_resume,
    input  logic        i_stop,
    input  logic [15:0] i_sram_data,
    output logic [19:0] o_address,
    output logic        o_dac_data,
    output logic        o_playing,
    output logic        o_wrap
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SYNC  = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        lrc_q;
    logic [15:0] shift_q, shift_d;
    logic [15:0] hold_q, hold_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        pause_pend_q, pause_pend_d;
    logic [19:0] addr_q, addr_d;
    logic        dac_q, dac_d;
    logic        wrap_q, wrap_d;

    logic fall, rise;
    assign fall = lrc_q & ~i_daclrck;
    assign rise = ~lrc_q & i_daclrck;

    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        bit_cnt_d    = bit_cnt_q;
        pause_pend_d = pause_pend_q;
        addr_d       = addr_q;
        dac_d        = dac_q;
        wrap_d       = 1'b0;

        if (i_stop) begin
            state_d      = S_IDLE;
            addr_d       = '0;
            dac_d        = 1'b0;
            pause_pend_d = 1'b0;
            bit_cnt_d    = '0;
        end else if (i_start) begin
            state_d      = S_SYNC;
            addr_d       = '0;
            dac_d        = 1'b0;
            pause_pend_d = 1'b0;
            bit_cnt_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: dac_d = 1'b0;
                S_SYNC: begin
                    dac_d = 1'b0;
                    if (fall) begin
                        state_d   = S_PLAY;
                        hold_d    = i_sram_data;
                        dac_d     = i_sram_data[15];
                        shift_d   = {i_sram_data[14:0], 1'b0};
                        bit_cnt_d = 5'd1;
                    end
                end
                S_PLAY: begin
                    if (i_pause) pause_pend_d = 1'b1;
                    if (fall && pause_pend_q) begin
                        state_d      = S_PAUSE;
                        dac_d        = 1'b0;
                        pause_pend_d = 1'b0;
                    end else if (fall) begin
                        hold_d    = i_sram_data;
                        dac_d     = i_sram_data[15];
                        shift_d   = {i_sram_data[14:0], 1'b0};
                        bit_cnt_d = 5'd1;
                    end else if (rise) begin
                        // Right half replays the held left sample; the frame ends here.
                        dac_d     = hold_q[15];
                        shift_d   = {hold_q[14:0], 1'b0};
                        bit_cnt_d = 5'd1;
                        wrap_d    = (addr_q == MAX_ADDR);
                        addr_d    = (addr_q == MAX_ADDR) ? '0 : addr_q + 20'd1;
                    end else if (bit_cnt_q >= 5'd1 && bit_cnt_q <= 5'd15) begin
                        dac_d     = shift_q[15];
                        shift_d   = {shift_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end else begin
                        dac_d = 1'b0;
                    end
                end
                default: begin
                    dac_d = 1'b0;
                    if (i_resume) state_d = S_SYNC;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: hold/shift are plain registers, not memories, so they take the async reset like the rest.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            lrc_q        <= 1'b0;
            shift_q      <= '0;
            hold_q       <= '0;
            bit_cnt_q    <= '0;
            pause_pend_q <= 1'b0;
            addr_q       <= '0;
            dac_q        <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lrc_q        <= i_daclrck;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            bit_cnt_q    <= bit_cnt_d;
            pause_pend_q <= pause_pend_d;
            addr_q       <= addr_d;
            dac_q        <= dac_d;
            wrap_q       <= wrap_d;
        end
    end

    assign o_address  = addr_q;
    assign o_dac_data = dac_q;
    assign o_wrap     = wrap_q;
    assign o_playing  = (state_q == S_SYNC) || (state_q == S_PLAY);

endmodule

// File: tb/tb_aud_player_loop.sv
// Bench for aud_player_loop: drives LRCK halves and commands, compares the serial stream,
// address, wrap pulse and playing flag against a frame-level playback model.
module tb_aud_player_loop;

    localparam logic [19:0] MAX = 20'd7;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_daclrck = 1'b0;
    logic        i_start = 1'b0;
    logic        i_pause = 1'b0;
    logic        i_resume = 1'b0;
    logic        i_stop = 1'b0;
    logic [15:0] i_sram_data;
    logic [19:0] o_address;
    logic        o_dac_data;
    logic        o_playing;
    logic        o_wrap;

    logic [15:0] mem [0:7];
    assign i_sram_data = mem[o_address[2:0]];

    aud_player_loop #(.MAX_ADDR(MAX)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_daclrck(i_daclrck),
        .i_start(i_start), .i_pause(i_pause), .i_resume(i_resume), .i_stop(i_stop),
        .i_sram_data(i_sram_data), .o_address(o_address), .o_dac_data(o_dac_data),
        .o_playing(o_playing), .o_wrap(o_wrap)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Player model: what a listener should hear, frame by frame.
    typedef enum int {M_IDLE, M_SYNC, M_PLAY, M_PAUSE} mode_e;
    mode_e mode   = M_IDLE;
    int    m_addr = 0;
    bit    m_pend = 1'b0;

    localparam int C_NONE = 0, C_PAUSE = 1, C_RESUME = 2, C_START = 3, C_STOP = 4,
                   C_BOTH = 5, C_RESET = 6;

    task automatic drive_cmd(input int cmd, input logic v);
        case (cmd)
            C_PAUSE:  i_pause = v;
            C_RESUME: i_resume = v;
            C_START:  i_start = v;
            C_STOP:   i_stop = v;
            C_BOTH:   begin i_start = v; i_stop = v; end
            default:  ;
        endcase
    endtask

    // One LRCK half of len BCLKs (8..32), optionally with a one-cycle command at negedge cj.
    task automatic play_half(input string tag, input int len, input int cj, input int cmd);
        logic        new_lvl;
        logic [15:0] smp;
        logic [31:0] obs, exp, mask;
        bit          active, exp_wrap, wrap_j1, wrap_other;
        int          cut;
        new_lvl  = ~i_daclrck;
        active   = 1'b0;
        exp_wrap = 1'b0;
        cut      = 0;
        smp      = mem[m_addr];
        if (!new_lvl) begin
            if (mode == M_SYNC) begin
                mode = M_PLAY; active = 1'b1;
            end else if (mode == M_PLAY) begin
                if (m_pend) begin mode = M_PAUSE; m_pend = 1'b0; end
                else active = 1'b1;
            end
        end else if (mode == M_PLAY) begin
            active   = 1'b1;
            exp_wrap = (m_addr == int'(MAX));
            m_addr   = exp_wrap ? 0 : m_addr + 1;
        end
        i_daclrck  = new_lvl;
        obs        = '0;
        wrap_j1    = 1'b0;
        wrap_other = 1'b0;
        for (int j = 1; j <= len; j++) begin
            @(negedge i_clk);
            obs = {obs[30:0], o_dac_data};
            if (j == 1) begin
                check({tag, "_addr_edge"}, 32'(o_address), 32'(m_addr));
                wrap_j1 = o_wrap;
            end else if (o_wrap) begin
                wrap_other = 1'b1;
            end
            if (cj > 0 && j == cj + 1) begin
                if (cmd == C_RESET) i_rst_n = 1'b1;
                else drive_cmd(cmd, 1'b0);
            end
            if (cj > 0 && j == cj) begin
                if (cmd == C_RESET) begin
                    #2 i_rst_n = 1'b0;
                    #1 check({tag, "_async_rst"}, 32'({o_address, o_dac_data, o_playing, o_wrap}), 32'h0);
                end else begin
                    drive_cmd(cmd, 1'b1);
                end
                case (cmd)
                    C_PAUSE:  if (mode == M_PLAY) m_pend = 1'b1;
                    C_RESUME: if (mode == M_PAUSE) mode = M_SYNC;
                    C_START:  begin mode = M_SYNC; m_addr = 0; m_pend = 1'b0; cut = j; end
                    C_STOP, C_BOTH, C_RESET: begin mode = M_IDLE; m_addr = 0; m_pend = 1'b0; cut = j; end
                    default: ;
                endcase
            end
        end
        exp = active ? ({smp, 16'h0} >> (32 - len)) : 32'h0;
        if (cut > 0) begin
            mask = (32'd1 << (len - cut)) - 32'd1;
            exp  = exp & ~mask;
        end
        check({tag, "_stream"}, obs, exp);
        check({tag, "_wrap"}, {30'h0, wrap_j1, wrap_other}, {30'h0, exp_wrap, 1'b0});
        check({tag, "_addr_end"}, 32'(o_address), 32'(m_addr));
        check({tag, "_playing"}, 32'(o_playing), 32'(mode == M_SYNC || mode == M_PLAY));
    endtask

    initial begin
        int guard;
        int len, cmd;
        for (int k = 0; k < 8; k++) mem[k] = 16'($urandom);
        mem[0] = 16'hA5C3;

        // Reset state
        #3 check("reset_state", 32'({o_address, o_dac_data, o_playing, o_wrap}), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Start while idle, then the A5C3 frame with 32-BCLK halves
        play_half("idle_start", 20, 3, C_START);
        play_half("t2_left", 32, 0, C_NONE);
        play_half("t2_right", 32, 0, C_NONE);

        // Eight random frames: runs through the 7->0 wrap
        for (int f = 0; f < 16; f++) play_half("frame", int'($urandom_range(17, 32)), 0, C_NONE);

        // Short halves cut serialisation
        for (int f = 0; f < 4; f++) play_half("short", int'($urandom_range(8, 16)), 0, C_NONE);

        // Pause at address 5, resume, expect address 6 next
        guard = 0;
        while (m_addr != 5 && guard < 16) begin
            play_half("seek", 18, 0, C_NONE);
            play_half("seek", 18, 0, C_NONE);
            guard++;
        end
        check("seek_addr5", 32'(o_address), 32'd5);
        play_half("pause_left", 24, 3, C_PAUSE);
        play_half("pause_right", 24, 0, C_NONE);
        play_half("paused_left", 24, 0, C_NONE);
        play_half("resume_right", 24, 4, C_RESUME);
        play_half("resumed_left", 24, 0, C_NONE);
        play_half("resumed_right", 24, 0, C_NONE);

        // Restart mid-play; pause ignored in sync, resume ignored in play
        play_half("restart", 24, 5, C_START);
        play_half("sync_pause", 24, 3, C_PAUSE);
        play_half("after_sync_pause", 24, 0, C_NONE);
        play_half("play_resume", 24, 4, C_RESUME);
        play_half("after_play_resume", 24, 0, C_NONE);
        play_half("after_play_resume", 24, 0, C_NONE);

        // Stop beats start in the same cycle
        play_half("start_stop", 24, 5, C_BOTH);
        play_half("stopped", 24, 0, C_NONE);

        // Async reset mid-frame, no resumption afterwards
        play_half("pre_rst", 20, 2, C_START);
        play_half("pre_rst", 20, 0, C_NONE);
        play_half("mid_rst", 24, 6, C_RESET);
        play_half("post_rst", 24, 0, C_NONE);
        play_half("post_rst", 24, 0, C_NONE);

        // Random commands and half lengths
        play_half("rnd_start", 20, 2, C_START);
        for (int f = 0; f < 40; f++) begin
            len = int'($urandom_range(8, 32));
            cmd = int'($urandom_range(0, 8));
            if (cmd > C_BOTH) cmd = C_NONE;
            play_half("rnd", len, (cmd == C_NONE) ? 0 : int'($urandom_range(1, len - 1)), cmd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
